// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite rendering blocks.
package sprite_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation frame sequencer: each frame is held for FRAME_HOLD frame_ticks, then
// the sequence advances and wraps after FRAMES. Restart returns to frame 0.
module sprite_anim_ctrl #(
    parameter int FRAMES     = 4,
    parameter int FRAME_HOLD = 8,
    parameter int FR_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    input  logic            frame_tick,
    input  logic            anim_en,
    input  logic            anim_restart,
    output logic [FR_W-1:0] frame
);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    logic [FR_W-1:0]   r_frame;
    logic [HOLD_W-1:0] r_hold;

    // Restart takes priority over a simultaneous tick advance.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= '0;
            r_hold  <= '0;
        end else if (anim_restart) begin
            r_frame <= '0;
            r_hold  <= '0;
        end else if (frame_tick && anim_en) begin
            if (r_hold == HOLD_W'(FRAME_HOLD - 1)) begin
                r_hold  <= '0;
                r_frame <= (r_frame == FR_W'(FRAMES - 1)) ? '0 : r_frame + 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign frame = r_frame;
endmodule

// File: rtl/sprite_renderer.sv
// Single scaled, mirrored, animated sprite on the VGA raster. Two-cycle pipeline:
// geometry/ROM address, synchronous ROM read, then palette lookup into output regs.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 16,
    parameter int SPR_H           = 16,
    parameter int IDX_BITS        = 4,
    parameter int SCALE_LOG2      = 1,
    parameter int FRAMES          = 4,
    parameter int FRAME_HOLD      = 8,
    parameter int TRANSPARENT_IDX = 0,
    parameter int ADDR_W          = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [COORD_W-1:0]  DrawX,
    input  logic [COORD_W-1:0]  DrawY,
    input  logic                blank,
    input  logic                frame_tick,
    input  logic [COORD_W-1:0]  pos_x,
    input  logic [COORD_W-1:0]  pos_y,
    input  logic                flip_h,
    input  logic                enable,
    input  logic                anim_en,
    input  logic                anim_restart,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS-1:0] pal_index,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                hit
);
    localparam int FR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TX_W = $clog2(SPR_W);
    localparam int TY_W = $clog2(SPR_H);
    localparam logic [COORD_W:0] BOX_W = (COORD_W + 1)'(SPR_W << SCALE_LOG2);
    localparam logic [COORD_W:0] BOX_H = (COORD_W + 1)'(SPR_H << SCALE_LOG2);

    logic [COORD_W-1:0] r_pos_x, r_pos_y;
    logic               r_flip_h, r_enable;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [1:0]         r_box_pipe, r_blank_pipe;
    logic [3:0]         r_red, r_green, r_blue;
    logic               r_hit;

    logic [FR_W-1:0]    w_frame;
    logic [COORD_W:0]   w_dx, w_dy;
    logic               w_in_box, w_opaque;
    logic [TX_W-1:0]    w_tx, w_tx_f;
    logic [TY_W-1:0]    w_ty;
    rgb12_t             w_rgb;

    sprite_anim_ctrl #(.FRAMES(FRAMES), .FRAME_HOLD(FRAME_HOLD), .FR_W(FR_W)) u_anim (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .frame        (w_frame)
    );

    // Placement registers only move during vblank so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_flip_h <= 1'b0;
            r_enable <= 1'b0;
        end else if (frame_tick) begin
            r_pos_x  <= pos_x;
            r_pos_y  <= pos_y;
            r_flip_h <= flip_h;
            r_enable <= enable;
        end
    end

    // Sign bit set means left of / above the sprite origin: clipped, never wrapped.
    assign w_dx     = {1'b0, DrawX} - {1'b0, r_pos_x};
    assign w_dy     = {1'b0, DrawY} - {1'b0, r_pos_y};
    assign w_in_box = !w_dx[COORD_W] && (w_dx < BOX_W) && !w_dy[COORD_W] && (w_dy < BOX_H);
    assign w_tx     = w_dx[SCALE_LOG2 +: TX_W];
    assign w_ty     = w_dy[SCALE_LOG2 +: TY_W];
    assign w_tx_f   = r_flip_h ? ~w_tx : w_tx;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr   <= '0;
            r_box_pipe   <= '0;
            r_blank_pipe <= '0;
        end else begin
            r_rom_addr   <= w_in_box ? ADDR_W'({w_frame, w_ty, w_tx_f}) : '0;
            r_box_pipe   <= {r_box_pipe[0], w_in_box};
            r_blank_pipe <= {r_blank_pipe[0], blank};
        end
    end

    assign pal_index = rom_q;
    assign w_rgb     = rgb12_t'(pal_rgb);
    assign w_opaque  = r_box_pipe[1] && r_blank_pipe[1] && r_enable &&
                       (rom_q != IDX_BITS'(TRANSPARENT_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_red   <= w_opaque ? w_rgb.r : 4'h0;
            r_green <= w_opaque ? w_rgb.g : 4'h0;
            r_blue  <= w_opaque ? w_rgb.b : 4'h0;
            r_hit   <= w_opaque;
        end
    end

    assign rom_addr = r_rom_addr;
    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign hit      = r_hit;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a behavioural synchronous ROM and palette.
module tb_sprite_renderer;
    localparam int ADDR_W = 10;

    logic              vga_clk, reset_n;
    logic [9:0]        DrawX, DrawY, pos_x, pos_y;
    logic              blank, frame_tick, flip_h, enable, anim_en, anim_restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_q, pal_index, red, green, blue;
    logic [11:0]       pal_rgb;
    logic              hit;
    logic              rom_zero;

    int errors = 0;
    int checks = 0;

    sprite_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
        .flip_h(flip_h), .enable(enable), .anim_en(anim_en), .anim_restart(anim_restart),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index), .pal_rgb(pal_rgb),
        .red(red), .green(green), .blue(blue), .hit(hit)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    function automatic logic [3:0] rom_of(input int a);
        return 4'((a % 15) + 1);
    endfunction

    function automatic logic [11:0] pal_of(input logic [3:0] i);
        return {i, ~i, i ^ 4'h5};
    endfunction

    initial rom_q = 4'h0;
    always @(posedge vga_clk) rom_q <= rom_zero ? 4'h0 : rom_of(int'(rom_addr));
    assign pal_rgb = pal_of(pal_index);

    // Called just after a negedge; returns just after a negedge.
    task automatic check_pix(input logic [9:0] x, input logic [9:0] y,
                             input logic [ADDR_W-1:0] ea, input logic eh, input string nm);
        logic [11:0] erg;
        DrawX = x;
        DrawY = y;
        @(posedge vga_clk);
        @(negedge vga_clk);
        checks++;
        if (rom_addr !== ea) begin
            errors++;
            $display("FAIL %s rom_addr x=%0d y=%0d got=%0d exp=%0d", nm, x, y, rom_addr, ea);
        end
        @(posedge vga_clk);
        @(posedge vga_clk);
        @(negedge vga_clk);
        erg = eh ? pal_of(rom_of(int'(ea))) : 12'h000;
        checks++;
        if (hit !== eh) begin
            errors++;
            $display("FAIL %s hit x=%0d y=%0d got=%b exp=%b", nm, x, y, hit, eh);
        end
        checks++;
        if ({red, green, blue} !== erg) begin
            errors++;
            $display("FAIL %s rgb x=%0d y=%0d got=%h exp=%h", nm, x, y, {red, green, blue}, erg);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge vga_clk);
        @(negedge vga_clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1; frame_tick = 1'b0;
        pos_x = 10'd0; pos_y = 10'd0; flip_h = 1'b0; enable = 1'b0;
        anim_en = 1'b0; anim_restart = 1'b0; rom_zero = 1'b0;
        repeat (3) @(negedge vga_clk);
        checks++;
        if ({hit, red, green, blue, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got hit=%b rgb=%h addr=%0d exp all 0",
                     hit, {red, green, blue}, rom_addr);
        end
        reset_n = 1'b1;
        @(negedge vga_clk);
        // enable shadow still 0: address computes but nothing is drawn
        check_pix(10'd5, 10'd5, 10'd34, 1'b0, "reset_disabled");
    endtask

    task automatic test_basic();
        enable = 1'b1; pos_x = 10'd100; pos_y = 10'd50;
        tick();
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "basic_origin");
        check_pix(10'd99, 10'd50, 10'd0, 1'b0, "basic_left");
        check_pix(10'd103, 10'd53, 10'd17, 1'b1, "basic_inner");
        check_pix(10'd100, 10'd82, 10'd0, 1'b0, "basic_below");
    endtask

    task automatic test_scale();
        for (int j = 0; j < 32; j++)
            check_pix(10'(100 + j), 10'd50, ADDR_W'(j >> 1), 1'b1, "scale_sweep");
        check_pix(10'd132, 10'd50, 10'd0, 1'b0, "scale_right");
    endtask

    task automatic test_flip();
        flip_h = 1'b1;
        tick();
        check_pix(10'd100, 10'd50, 10'd15, 1'b1, "flip_left");
        check_pix(10'd131, 10'd50, 10'd0, 1'b1, "flip_right");
        flip_h = 1'b0;
        tick();
    endtask

    task automatic test_transparent();
        rom_zero = 1'b1;
        check_pix(10'd100, 10'd50, 10'd0, 1'b0, "transparent");
        rom_zero = 1'b0;
        blank = 1'b0;
        check_pix(10'd102, 10'd50, 10'd1, 1'b0, "blanked");
        blank = 1'b1;
    endtask

    task automatic test_anim();
        anim_en = 1'b1;
        repeat (8) tick();
        check_pix(10'd100, 10'd50, 10'd256, 1'b1, "anim_frame1");
        repeat (24) tick();
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "anim_wrap");
        repeat (8) tick();
        check_pix(10'd102, 10'd50, 10'd257, 1'b1, "anim_frame1b");
        anim_restart = 1'b1;
        tick();
        anim_restart = 1'b0;
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "anim_restart");
        repeat (7) tick();
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "anim_hold_cleared");
        tick();
        check_pix(10'd100, 10'd50, 10'd256, 1'b1, "anim_after_restart");
        anim_en = 1'b0;
        repeat (8) tick();
        check_pix(10'd100, 10'd50, 10'd256, 1'b1, "anim_frozen");
        anim_restart = 1'b1;
        @(posedge vga_clk);
        @(negedge vga_clk);
        anim_restart = 1'b0;
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "anim_restart_notick");
    endtask

    task automatic test_shadow_clip();
        pos_x = 10'd200;
        check_pix(10'd100, 10'd50, 10'd0, 1'b1, "shadow_old_pos");
        check_pix(10'd200, 10'd50, 10'd0, 1'b0, "shadow_new_pos");
        pos_x = 10'd630;
        tick();
        check_pix(10'd630, 10'd50, 10'd0, 1'b1, "clip_630");
        check_pix(10'd639, 10'd50, 10'd4, 1'b1, "clip_639");
        check_pix(10'd0, 10'd50, 10'd0, 1'b0, "clip_nowrap0");
        check_pix(10'd21, 10'd50, 10'd0, 1'b0, "clip_nowrap21");
        pos_x = 10'd100;
        tick();
    endtask

    task automatic test_reset_midline();
        check_pix(10'd104, 10'd50, 10'd2, 1'b1, "midline_pre");
        reset_n = 1'b0;
        #1;
        checks++;
        if ({hit, red, green, blue, rom_addr} !== '0) begin
            errors++;
            $display("FAIL midline_reset got hit=%b rgb=%h addr=%0d exp all 0",
                     hit, {red, green, blue}, rom_addr);
        end
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check_pix(10'd104, 10'd50, 10'd0, 1'b0, "midline_post");
    endtask

    initial begin
        @(negedge vga_clk);
        test_reset();
        test_basic();
        test_scale();
        test_flip();
        test_transparent();
        test_anim();
        test_shadow_clip();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
